// File: rtl/serial_sub2comp_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands. The slave returns the results and status.
interface serial_sub2comp_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             b_in;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, x, y, b_in,
        input  diff, b_out, ovf, busy, done
    );

    modport slave (
        input  start, x, y, b_in,
        output diff, b_out, ovf, busy, done
    );
endinterface

// File: rtl/serial_sub2comp.sv
// Bit-serial two's-complement subtractor: diff = x - y - b_in, LSB first.
// It uses one full-adder slice and a carry flop, and takes WIDTH shift cycles per operation.
module serial_sub2comp #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    serial_sub2comp_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xs, ys;
    logic [WIDTH-2:0] r;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    cnt;
    logic             c, c_nxt, s;
    logic             x_msb, y_msb;
    logic             capture, last;
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q, ovf_q;

    // Subtraction is computed as x + ~y + ~b_in. The carry out is the inverted borrow.
    always_comb begin
        s       = xs[0] ^ ys[0] ^ c;
        c_nxt   = (xs[0] & ys[0]) | (xs[0] & c) | (ys[0] & c);
        r_shift = {s, r};
        capture = bus.start && (state_q != SHIFT);
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = bus.start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xs      <= '0;
            ys      <= '0;
            r       <= '0;
            cnt     <= '0;
            c       <= 1'b0;
            x_msb   <= 1'b0;
            y_msb   <= 1'b0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                xs    <= bus.x;
                ys    <= ~bus.y;
                x_msb <= bus.x[WIDTH-1];
                y_msb <= bus.y[WIDTH-1];
                c     <= ~bus.b_in;
                cnt   <= '0;
            end else if (state_q == SHIFT) begin
                c   <= c_nxt;
                r   <= r_shift[WIDTH-1:1];
                xs  <= xs >> 1;
                ys  <= ys >> 1;
                cnt <= cnt + CW'(1);
                // The result is registered on the final shift, so it is valid during DONE.
                if (last) begin
                    diff_q  <= r_shift;
                    b_out_q <= ~c_nxt;
                    ovf_q   <= (x_msb != y_msb) && (s != x_msb);
                end
            end
        end
    end

    assign bus.diff  = diff_q;
    assign bus.b_out = b_out_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
endmodule

// File: tb/tb_serial_sub2comp.sv
// Directed and exhaustive checks of the WIDTH=4 bit-serial subtractor.
module tb_serial_sub2comp;
    logic clk = 1'b0;
    logic rst;
    int   applied = 0;
    int   miscompares = 0;

    serial_sub2comp_if #(.WIDTH(4)) bus ();
    serial_sub2comp #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] xv, input logic [3:0] yv, input logic bv);
        bus.x    = xv;
        bus.y    = yv;
        bus.b_in = bv;
    endtask

    function automatic logic [5:0] model(input logic [3:0] xv, input logic [3:0] yv, input logic bv);
        int ux, uy, sx, sy, bi, d, sd;
        ux = int'({28'd0, xv});
        uy = int'({28'd0, yv});
        bi = int'({31'd0, bv});
        sx = xv[3] ? ux - 16 : ux;
        sy = yv[3] ? uy - 16 : uy;
        d  = ux - uy - bi;
        sd = sx - sy - bi;
        return {d[3:0], d < 0, (sd < -8) || (sd > 7)};
    endfunction

    task automatic run_op(input logic [3:0] xv, input logic [3:0] yv, input logic bv,
                          output int lat, output int busy_n, output int overlap);
        drive(xv, yv, bv);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1; busy_n = 0; overlap = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_n++;
            tick();
            lat++;
        end
        if (bus.busy && bus.done) overlap++;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; drive(4'h0, 4'h0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        applied++;
        if ({bus.diff, bus.b_out, bus.ovf, bus.busy, bus.done} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got %b want 00000000",
                     {bus.diff, bus.b_out, bus.ovf, bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        // {x, y, b_in, diff, b_out, ovf}
        logic [14:0] vec [5] = '{
            {4'b1001, 4'b0110, 1'b0, 4'b0011, 1'b0, 1'b1},
            {4'b0010, 4'b1110, 1'b0, 4'b0100, 1'b1, 1'b0},
            {4'b1010, 4'b1111, 1'b1, 4'b1010, 1'b1, 1'b0},
            {4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1},
            {4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0, 1'b0}
        };
        int lat, busy_n, overlap;
        for (int i = 0; i < 5; i++) begin
            run_op(vec[i][14:11], vec[i][10:7], vec[i][6], lat, busy_n, overlap);
            applied++;
            if (lat !== 5) begin
                miscompares++;
                $display("FAIL basic_latency[%0d]: got %0d want 5", i, lat);
            end
            applied++;
            if (busy_n !== 4) begin
                miscompares++;
                $display("FAIL basic_busy_cycles[%0d]: got %0d want 4", i, busy_n);
            end
            applied++;
            if (overlap !== 0) begin
                miscompares++;
                $display("FAIL basic_busy_done_overlap[%0d]: got %0d want 0", i, overlap);
            end
            applied++;
            if ({bus.diff, bus.b_out, bus.ovf} !== vec[i][5:0]) begin
                miscompares++;
                $display("FAIL basic_result[%0d]: got %b want %b", i,
                         {bus.diff, bus.b_out, bus.ovf}, vec[i][5:0]);
            end
            tick();
            applied++;
            if (bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_done_width[%0d]: got %b want 0", i, bus.done);
            end
        end
    endtask

    task automatic test_handshake();
        int n_done, flaws, n;
        logic [5:0] res;
        // Second start during SHIFT with changed operands: ignored, result from the first capture.
        drive(4'b0011, 4'b0001, 1'b0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick();
        bus.start = 1'b1; drive(4'b1111, 4'b1111, 1'b1);
        tick();
        bus.start = 1'b0; drive(4'b0110, 4'b1001, 1'b1);
        n_done = 0; res = '0;
        for (int k = 0; k < 10; k++) begin
            if (bus.done) begin
                n_done++;
                res = {bus.diff, bus.b_out, bus.ovf};
            end
            tick();
        end
        applied++;
        if (n_done !== 1) begin
            miscompares++;
            $display("FAIL ignored_start_done_count: got %0d want 1", n_done);
        end
        applied++;
        if (res !== 6'b0010_0_0) begin
            miscompares++;
            $display("FAIL ignored_start_result: got %b want 001000", res);
        end
        // Outputs must hold the previous result (0010,0,0) through the next SHIFT.
        drive(4'b1000, 4'b0001, 1'b0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        flaws = 0;
        for (int k = 0; k < 4; k++) begin
            if ({bus.diff, bus.b_out, bus.ovf} !== 6'b0010_0_0 || bus.busy !== 1'b1) flaws++;
            tick();
        end
        applied++;
        if (flaws !== 0) begin
            miscompares++;
            $display("FAIL stable_during_shift: got %0d bad cycles want 0", flaws);
        end
        applied++;
        if ({bus.done, bus.diff, bus.b_out, bus.ovf} !== 7'b1_0111_0_1) begin
            miscompares++;
            $display("FAIL neg_overflow_result: got %b want 1011101",
                     {bus.done, bus.diff, bus.b_out, bus.ovf});
        end
        tick();
        // Start held high across DONE: the next operation begins with no IDLE cycle.
        drive(4'b0001, 4'b0001, 1'b0);
        bus.start = 1'b1; tick();
        n = 1;
        while (!bus.done && n < 20) begin tick(); n++; end
        applied++;
        if ({bus.done, bus.diff, bus.b_out, bus.ovf} !== 7'b1_0000_0_0) begin
            miscompares++;
            $display("FAIL b2b_first_result: got %b want 1000000",
                     {bus.done, bus.diff, bus.b_out, bus.ovf});
        end
        drive(4'b0000, 4'b0001, 1'b0);
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 20) begin tick(); n++; end
        applied++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL b2b_done_spacing: got %0d want 5", n);
        end
        applied++;
        if ({bus.diff, bus.b_out, bus.ovf} !== 6'b1111_1_0) begin
            miscompares++;
            $display("FAIL b2b_second_result: got %b want 111110", {bus.diff, bus.b_out, bus.ovf});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n_done, n_act, lat, busy_n, overlap;
        drive(4'b0101, 4'b0010, 1'b0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        applied++;
        if ({bus.diff, bus.b_out, bus.ovf, bus.busy, bus.done} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %b want 00000000",
                     {bus.diff, bus.b_out, bus.ovf, bus.busy, bus.done});
        end
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done) n_done++;
            tick();
        end
        applied++;
        if (n_done !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d want 0", n_done);
        end
        run_op(4'b0101, 4'b0010, 1'b0, lat, busy_n, overlap);
        applied++;
        if ({lat[3:0], bus.diff, bus.b_out, bus.ovf} !== {4'd5, 6'b0011_0_0}) begin
            miscompares++;
            $display("FAIL after_reset_op: got lat %0d res %b want lat 5 res 001100",
                     lat, {bus.diff, bus.b_out, bus.ovf});
        end
        tick();
        // rst wins over start in the same cycle.
        drive(4'b1100, 4'b0011, 1'b1);
        rst = 1'b1; bus.start = 1'b1; tick();
        rst = 1'b0; bus.start = 1'b0;
        n_act = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.busy || bus.done) n_act++;
            tick();
        end
        applied++;
        if (n_act !== 0) begin
            miscompares++;
            $display("FAIL rst_start_same_cycle: got %0d active cycles want 0", n_act);
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] idx;
        logic [5:0] exp_res;
        int n;
        idx = '0;
        drive(idx[8:5], idx[4:1], idx[0]);
        exp_res = model(idx[8:5], idx[4:1], idx[0]);
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 512; i++) begin
            n = 1;
            while (!bus.done && n < 20) begin tick(); n++; end
            applied++;
            if (n !== 5) begin
                miscompares++;
                $display("FAIL exh_spacing[%0d]: got %0d want 5", i, n);
            end
            applied++;
            if ({bus.diff, bus.b_out, bus.ovf} !== exp_res) begin
                miscompares++;
                $display("FAIL exh_result[x=%b y=%b b=%b]: got %b want %b", idx[8:5], idx[4:1],
                         idx[0], {bus.diff, bus.b_out, bus.ovf}, exp_res);
            end
            if (i < 511) begin
                idx = 9'(i + 1);
                drive(idx[8:5], idx[4:1], idx[0]);
                exp_res = model(idx[8:5], idx[4:1], idx[0]);
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_handshake();
        test_reset_mid();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_sub2comp.md
# serial_sub2comp

Bit-serial two's-complement subtractor with borrow-in. It computes diff = x − y − b_in over WIDTH clock cycles, LSB first, using a single full-adder slice and a carry flip-flop. It sits beside the parallel 2's-complement adder in the arithmetic assignments as its inverse operation, trading area for latency. A start/done handshake frames each operation.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high, one clock
- start  input  1  request; sampled on rising clk
- x  input  WIDTH  minuend, two's complement
- y  input  WIDTH  subtrahend, two's complement
- b_in  input  1  borrow in (1 = subtract one more)
- diff  output  WIDTH  result x − y − b_in mod 2^WIDTH
- b_out  output  1  unsigned borrow out (1 when x < y + b_in as unsigned)
- ovf  output  1  signed overflow of the subtraction
- busy  output  1  high while shifting
- done  output  1  one-cycle pulse; diff/b_out/ovf valid from this cycle

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. On start=1:
  - capture x into shift register XS and ~y into YS;
  - record x[WIDTH-1] and y[WIDTH-1] for overflow;
  - set carry c = ~b_in;
  - clear the bit counter;
  - go to SHIFT.
- SHIFT: busy=1. Each cycle:
  - s = XS[0] ^ YS[0] ^ c; c ← majority(XS[0], YS[0], c);
  - shift s into the MSB of result register R (R shifts right);
  - shift XS and YS right;
  - count += 1.
  - After the WIDTH-th shift, go to DONE.
- DONE: done=1, busy=0.
  - diff = R; b_out = ~c.
  - ovf = (xs_msb != ys_msb_orig) && (R[WIDTH-1] != xs_msb).
  - Next state is IDLE, or SHIFT if start=1 (back-to-back operation, new operands captured this cycle).
- Outputs diff, b_out and ovf are registered. They hold their last value until the next DONE, and do not change during SHIFT; R is a separate shadow register.
- start is ignored while in SHIFT. Operands are only read in the capture cycle, so x, y and b_in may change freely afterwards.
- Counter width: clog2(WIDTH)+1 bits. Counter wrap is never reached because the state leaves SHIFT at count = WIDTH−1.

## Timing
- Reset (rst=1 at rising edge, any state, including mid-SHIFT):
  - state=IDLE, diff=0, b_out=0, ovf=0, busy=0, done=0, counter=0, c=0;
  - any operation in progress is discarded, with no done pulse.
- rst has priority over start in the same cycle.
- Latency: start accepted at edge T; busy high for cycles T+1 … T+WIDTH; done high in cycle T+WIDTH+1 with valid results.
- Throughput: one result per WIDTH+1 cycles when start is held high or reasserted in DONE.
- done is exactly one cycle wide. busy and done are never high together.
- start held high continuously produces one back-to-back operation per WIDTH+1 cycles, re-capturing operands in each DONE cycle.

## Test plan
- Basic subtraction: WIDTH=4, x=1001, y=0110, b_in=0, start pulse -> done 5 cycles after the start edge; diff=0011, b_out=0, ovf=1 (−7−6 overflows); busy high exactly 4 cycles.
- Unsigned borrow: x=0010, y=1110, b_in=0 -> diff=0100, b_out=1, ovf=0.
- Borrow-in: x=1010, y=1111, b_in=1 -> diff=1010, b_out=1, ovf=0. Positive overflow: x=0111, y=1000, b_in=0 -> diff=1111, b_out=1, ovf=1.
- Handshake: pulse start again during SHIFT -> ignored, single done; hold start high across DONE -> second operation begins with no IDLE cycle, done pulses 5 cycles apart; operands changed after capture -> result unaffected; outputs stable through SHIFT.
- Reset mid-operation: assert rst in the 2nd SHIFT cycle -> next cycle all outputs 0, state IDLE, no done pulse; a following start completes normally. Also rst and start in the same cycle -> stays IDLE.
- Exhaustive: all 16×16×2 operand/borrow combinations back-to-back, compared against the reference model (x − y − b_in) mod 16, with unsigned borrow and signed overflow checked.
